// File: rtl/neuron_accum.sv
// Integrate-and-fire membrane accumulator driving an external 9-bit adder.
// Optional leak on each update is enabled by defining NEURON_ACCUM_LEAK_EN.
module neuron_accum #(
    parameter int         ADD_WAIT   = 2,
    parameter logic [8:0] THRESH     = 9'd256,
    parameter int         REFRACT    = 4,
    parameter int         LEAK_SHIFT = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       syn_valid,
    input  logic [8:0] syn_weight,
    output logic       syn_ready,
    output logic [8:0] add_a,
    output logic [8:0] add_b,
    output logic       add_cin,
    input  logic [8:0] sum_in,
    input  logic       cout_in,
    output logic [8:0] vmem,
    output logic       spike
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        FIRE = 2'd2,
        REFR = 2'd3
    } state_t;

    localparam logic [3:0] ADD_LAST  = 4'(ADD_WAIT - 1);
    localparam logic [3:0] REFR_LAST = 4'(REFRACT - 1);

    if (ADD_WAIT < 1 || ADD_WAIT > 15 || REFRACT < 1 || REFRACT > 15 ||
        LEAK_SHIFT < 0 || LEAK_SHIFT > 8) begin : g_param_check
        $error("neuron_accum: parameter out of range");
    end

    state_t     state_r, state_s;
    logic [3:0] cnt_r, cnt_s;
    logic [8:0] vmem_r, vmem_s;
    logic [8:0] add_b_r, add_b_s;
    logic       spike_r, spike_s;
    logic       ready_r, ready_s;
    logic [8:0] sample_s;

    // Carry-out means the true sum exceeded 9 bits, so clamp to full scale.
    function automatic logic [8:0] sample_value(input logic [8:0] sum, input logic cout);
        logic [8:0] sat;
        sat = cout ? 9'h1FF : sum;
`ifdef NEURON_ACCUM_LEAK_EN
        return sat - (sat >> LEAK_SHIFT);
`else
        return sat;
`endif
    endfunction

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            cnt_r   <= 4'd0;
            vmem_r  <= 9'd0;
            add_b_r <= 9'd0;
            spike_r <= 1'b0;
            ready_r <= 1'b1;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            vmem_r  <= vmem_s;
            add_b_r <= add_b_s;
            spike_r <= spike_s;
            ready_r <= ready_s;
        end
    end

    // Next-state and next-register computation.
    always_comb begin
        state_s  = state_r;
        cnt_s    = cnt_r;
        vmem_s   = vmem_r;
        add_b_s  = add_b_r;
        spike_s  = 1'b0;
        sample_s = sample_value(sum_in, cout_in);
        case (state_r)
            IDLE: begin
                if (syn_valid && ready_r) begin
                    add_b_s = syn_weight;
                    cnt_s   = ADD_LAST;
                    state_s = ADD;
                end else begin
                    state_s = IDLE;
                end
            end
            ADD: begin
                if (cnt_r == 4'd0) begin
                    if (sample_s >= THRESH) begin
                        vmem_s  = 9'd0;
                        spike_s = 1'b1;
                        state_s = FIRE;
                    end else begin
                        vmem_s  = sample_s;
                        state_s = IDLE;
                    end
                end else begin
                    cnt_s = cnt_r - 4'd1;
                end
            end
            FIRE: begin
                cnt_s   = REFR_LAST;
                state_s = REFR;
            end
            REFR: begin
                if (cnt_r == 4'd0) begin
                    state_s = IDLE;
                end else begin
                    cnt_s = cnt_r - 4'd1;
                end
            end
            default: begin
                state_s = IDLE;
                cnt_s   = 4'd0;
            end
        endcase
        // Ready is registered, so it reflects the state being entered.
        ready_s = (state_s == IDLE);
    end

    assign syn_ready = ready_r;
    assign add_a     = vmem_r;
    assign add_b     = add_b_r;
    assign add_cin   = 1'b0;
    assign vmem      = vmem_r;
    assign spike     = spike_r;

endmodule
